// File: rtl/uart_byte_rx_pkg.sv
// rtl/uart_byte_rx_pkg.sv - shared receiver state encoding, frame constants and width helper
//
// Purpose: definitions shared by the UART byte receiver and its bit timer.
// The transmit block is expected to reuse the same constants and helper.
// Ports: none (package).

package uart_byte_rx_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_WAIT_HI = 3'd4
  } rx_state_e;

  // Bits needed to hold values 0..value-1; never less than 1.
  function automatic int clog2w(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/uart_byte_rx_if.sv
// rtl/uart_byte_rx_if.sv - valid/ready byte output bundle of the UART receiver
//
// Purpose: groups the received-byte handshake.
// Signals:
//   rx_data   8  received byte, stable while rx_valid=1 and rx_ready=0
//   rx_valid  1  byte available, held until accepted
//   rx_ready  1  consumer accepts when rx_valid & rx_ready at posedge
// Modports: master = receiver (drives data/valid), slave = consumer.

interface uart_byte_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_byte_rx_bit_timer.sv
// rtl/uart_byte_rx_bit_timer.sv - enable-gated bit timer with half/full terminal pulses
//
// Purpose: counts system clocks within a bit period for the receiver FSM.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en_i        count enable
//   clr_i       synchronous clear (wins over enable)
//   half_o      count == CLK_DIV/2-1 while enabled (mid start bit)
//   full_o      count == CLK_DIV-1 while enabled (mid data/stop bit)

module uart_byte_rx_bit_timer
  import uart_byte_rx_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic half_o,
  output logic full_o
);

  localparam int            TW      = clog2w(CLK_DIV);
  localparam logic [TW-1:0] HALF_TC = TW'(CLK_DIV / 2 - 1);
  localparam logic [TW-1:0] FULL_TC = TW'(CLK_DIV - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      // Wrap rather than overflow if the FSM ever fails to clear.
      cnt_d = (cnt_q == FULL_TC) ? '0 : cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign half_o = en_i && (cnt_q == HALF_TC);
  assign full_o = en_i && (cnt_q == FULL_TC);

endmodule

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 UART byte receiver with valid/ready output
//
// Purpose: receives asynchronous 8N1 frames on rxd, samples mid-bit, and
// presents each byte on a valid/ready handshake.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   rxd         raw serial input, idle high, asynchronous to clk
//   rx_bus      master side of uart_byte_rx_if (rx_data/rx_valid out, rx_ready in)
//   frame_err   1-cycle pulse: stop bit sampled low
//   overrun     1-cycle pulse: byte completed while previous one unaccepted
//   busy        high whenever the FSM is not idle

module uart_byte_rx
  import uart_byte_rx_pkg::*;
#(
  parameter int CLK_DIV   = 434,
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rxd,
  uart_byte_rx_if.master        rx_bus,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

  logic                 rxd_meta_q, rxs_q;
  rx_state_e            state_q, state_d;
  logic                 tmr_en, tmr_clr, half_tc, full_tc;
  logic                 shift_en, idx_clr, commit, ferr_set;
  logic [DATA_BITS-1:0] shift_q;
  logic [2:0]           idx_q;
  logic [7:0]           rx_data_q;
  logic                 rx_valid_q, ferr_q, ovr_q;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxs_q      <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxs_q      <= rxd_meta_q;
    end
  end

  uart_byte_rx_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (tmr_en),
    .clr_i  (tmr_clr),
    .half_o (half_tc),
    .full_o (full_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    tmr_en   = 1'b0;
    tmr_clr  = 1'b0;
    shift_en = 1'b0;
    idx_clr  = 1'b0;
    commit   = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (!rxs_q) state_d = ST_START;
      end
      ST_START: begin
        tmr_en = 1'b1;
        if (half_tc) begin
          tmr_clr = 1'b1;
          if (rxs_q) begin
            state_d = ST_IDLE;          // too short to be a start bit
          end else begin
            idx_clr = 1'b1;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        tmr_en = 1'b1;
        if (full_tc) begin
          tmr_clr  = 1'b1;
          shift_en = 1'b1;
          if (idx_q == IDX_LAST) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        tmr_en = 1'b1;
        if (full_tc) begin
          tmr_clr = 1'b1;
          if (rxs_q) begin
            commit  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = ST_WAIT_HI;      // line held low: wait for it to recover
          end
        end
      end
      ST_WAIT_HI: begin
        if (rxs_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // LSB arrives first, so shift in from the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      if (idx_clr)       idx_q <= '0;
      else if (shift_en) idx_q <= idx_q + 3'd1;
      if (shift_en) shift_q <= {rxs_q, shift_q[DATA_BITS-1:1]};
    end
  end

  // A commit may load over a byte that is being accepted in the same cycle;
  // otherwise a pending byte wins and the new one is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      ferr_q <= ferr_set;
      ovr_q  <= 1'b0;
      if (commit) begin
        if (!rx_valid_q || rx_bus.rx_ready) begin
          rx_data_q  <= shift_q[7:0];
          rx_valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_bus.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_bus.rx_data  = rx_data_q;
  assign rx_bus.rx_valid = rx_valid_q;
  assign frame_err       = ferr_q;
  assign overrun         = ovr_q;
  assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb/tb_uart_byte_rx.sv - scoreboard testbench for uart_byte_rx

module tb_uart_byte_rx;

  localparam int CLK_DIV = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rxd   = 1'b1;
  logic frame_err, overrun, busy;

  uart_byte_rx_if bus ();

  uart_byte_rx #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rx_bus    (bus),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  int         valid_cycles = 0;
  bit         rand_ready_en = 1'b0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted byte.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n) begin
      if (bus.rx_valid) valid_cycles++;
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (frame_err || overrun) check("pulse_exclusive", {31'd0, frame_err & overrun}, 32'd0);
      if (prev_hold && bus.rx_valid) check("data_hold", {24'd0, bus.rx_data}, {24'd0, prev_data});
      if (bus.rx_valid && bus.rx_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_byte: got %02h, expected none", bus.rx_data);
        end else begin
          e = exp_q.pop_front();
          check("rx_byte", {24'd0, bus.rx_data}, {24'd0, e});
        end
      end
      prev_hold = bus.rx_valid && !bus.rx_ready;
      prev_data = bus.rx_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready_en) bus.rx_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_valid"}, {31'd0, bus.rx_valid}, 32'd0);
    check({tag, "_rx_data"}, {24'd0, bus.rx_data}, 32'd0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Drives one frame: start, 8 data bits LSB first, stop. Optionally raises
  // rx_ready for the single cycle in which the receiver samples the stop bit
  // (half a bit plus two synchroniser clocks into the stop bit).
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit rdy_pulse);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < CLK_DIV; j++) begin
        tick();
        if (j == 0) rxd = bits[i];
        if (rdy_pulse && i == 9 && j == CLK_DIV / 2 + 2) bus.rx_ready = 1'b1;
        if (rdy_pulse && i == 9 && j == CLK_DIV / 2 + 3) bus.rx_ready = 1'b0;
      end
    end
  endtask

  // Starts a frame and pulses reset in the middle of data bit abort_bit.
  task automatic send_aborted(input logic [7:0] b, input int abort_bit);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i <= abort_bit; i++) begin
      for (int j = 0; j < CLK_DIV; j++) begin
        tick();
        if (j == 0) rxd = bits[i];
        if (i == abort_bit && j == CLK_DIV / 2) begin
          @(negedge clk);
          check("abort_busy_before", {31'd0, busy}, 32'd1);
          rst_n = 1'b0;
          rxd   = 1'b1;
          #1;
          check_reset_outputs("abort");
          tick();
          rst_n = 1'b1;
          return;
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  v0, f0, o0;
    bit  found;
    logic [7:0] b;

    bus.rx_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    repeat (5) tick();

    // 0xA5 with consumer always ready: exactly one valid cycle.
    v0 = valid_cycles; f0 = ferr_cnt; o0 = ovr_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (20) tick();
    check("a5_valid_cycles", valid_cycles - v0, 1);
    check("a5_frame_err", ferr_cnt - f0, 0);
    check("a5_overrun", ovr_cnt - o0, 0);

    // Four-clock low glitch: start detection abandons it.
    v0 = valid_cycles; f0 = ferr_cnt; o0 = ovr_cnt;
    tick(); rxd = 1'b0;
    repeat (3) tick();
    tick(); rxd = 1'b1;
    @(negedge clk);
    check("glitch_busy_seen", {31'd0, busy}, 32'd1);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (!busy) found = 1'b1;
    end
    check("glitch_busy_clears", {31'd0, found}, 32'd1);
    repeat (10) tick();
    check("glitch_no_valid", valid_cycles - v0, 0);
    check("glitch_no_frame_err", ferr_cnt - f0, 0);
    check("glitch_no_overrun", ovr_cnt - o0, 0);

    // 0x3C with a low stop bit, line then held low.
    v0 = valid_cycles; f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) tick();
    @(negedge clk);
    check("break_busy_held", {31'd0, busy}, 32'd1);
    check("break_frame_err", ferr_cnt - f0, 1);
    check("break_no_valid", valid_cycles - v0, 0);
    tick(); rxd = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk);
      if (!busy) found = 1'b1;
    end
    check("break_busy_clears", {31'd0, found}, 32'd1);
    check("break_no_overrun", ovr_cnt - o0, 0);
    repeat (5) tick();

    // Consumer stalled: second byte is dropped with one overrun pulse.
    o0 = ovr_cnt; f0 = ferr_cnt;
    bus.rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    repeat (4) tick();
    @(negedge clk);
    check("ovr_pulses", ovr_cnt - o0, 1);
    check("ovr_valid_held", {31'd0, bus.rx_valid}, 32'd1);
    check("ovr_data_held", {24'd0, bus.rx_data}, 32'h11);
    tick(); bus.rx_ready = 1'b1;
    tick(); bus.rx_ready = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("ovr_drained", exp_q.size(), 0);
    check("ovr_valid_drops", {31'd0, bus.rx_valid}, 32'd0);
    check("ovr_no_frame_err", ferr_cnt - f0, 0);

    // Accept the pending byte in the very cycle the next one commits.
    o0 = ovr_cnt;
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h55);
    send_frame(8'h44, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b1);
    @(negedge clk);
    check("coinc_valid", {31'd0, bus.rx_valid}, 32'd1);
    check("coinc_data", {24'd0, bus.rx_data}, 32'h55);
    check("coinc_no_overrun", ovr_cnt - o0, 0);
    check("coinc_one_left", exp_q.size(), 1);
    tick(); bus.rx_ready = 1'b1;
    repeat (3) tick();

    // Reset mid-frame, then a clean frame.
    v0 = valid_cycles; f0 = ferr_cnt; o0 = ovr_cnt;
    send_aborted(8'hFF, 3);
    repeat (5) tick();
    @(negedge clk);
    check("abort_idle_after", {31'd0, busy}, 32'd0);
    check("abort_no_valid", valid_cycles - v0, 0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, 1'b0);
    repeat (20) tick();
    check("post_abort_valid", valid_cycles - v0, 1);
    check("abort_no_pulses", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

    // Random bytes, random gaps, randomly stalling consumer.
    o0 = ovr_cnt; f0 = ferr_cnt;
    rand_ready_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, 1'b1, 1'b0);
      repeat ($urandom_range(0, 30)) tick();
    end
    rand_ready_en = 1'b0;
    bus.rx_ready = 1'b1;
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) tick();
    repeat (3) tick();
    check("random_drained", exp_q.size(), 0);
    check("random_no_overrun", ovr_cnt - o0, 0);
    check("random_no_frame_err", ferr_cnt - f0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
